// File: rtl/reg_shift_sequencer.sv
// Iterative 1-bit/cycle ARM register-specified shifter (LSL/LSR/ASR/ROR by Rs[7:0]).
// Holds the pipeline through stall while the shift runs, then pulses done with Val2/carry valid.
module reg_shift_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  shift_type,
   input  logic [31:0] Val_Rm,
   input  logic [7:0]  Val_Rs,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] Val2,
   output logic        shifter_carry
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, next_state;
   logic [31:0] result;
   logic        carry;
   logic [1:0]  type_q;
   logic [5:0]  count;
   logic [5:0]  eff_count;
   logic        accept;

   // Shifting one step past 32 is what clears the carry for LSL/LSR amounts above 32;
   // ASR saturates at 32 because every later step would reproduce the same result.
   always_comb begin
      eff_count = '0;
      case (shift_type)
         2'b00, 2'b01: eff_count = (Val_Rs > 8'd33) ? 6'd33 : Val_Rs[5:0];
         2'b10:        eff_count = (Val_Rs > 8'd32) ? 6'd32 : Val_Rs[5:0];
         default: begin
            if (Val_Rs == 8'd0)
               eff_count = 6'd0;
            else if (Val_Rs[4:0] == 5'd0)
               eff_count = 6'd32;
            else
               eff_count = {1'b0, Val_Rs[4:0]};
         end
      endcase
   end

   assign accept = start && ((state == IDLE) || (state == DONE));

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (accept)
               next_state = (eff_count != 6'd0) ? SHIFT : DONE;
            else
               next_state = IDLE;
         end
         SHIFT: begin
            if (count == 6'd1)
               next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Datapath: start while SHIFT is running is deliberately not looked at here.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         carry  <= 1'b0;
         type_q <= 2'b00;
         count  <= '0;
      end else if (accept) begin
         result <= Val_Rm;
         carry  <= carry_in;
         type_q <= shift_type;
         count  <= eff_count;
      end else if (state == SHIFT) begin
         count <= count - 6'd1;
         case (type_q)
            2'b00: begin
               carry  <= result[31];
               result <= {result[30:0], 1'b0};
            end
            2'b01: begin
               carry  <= result[0];
               result <= {1'b0, result[31:1]};
            end
            2'b10: begin
               carry  <= result[0];
               result <= {result[31], result[31:1]};
            end
            default: begin
               carry  <= result[0];
               result <= {result[0], result[31:1]};
            end
         endcase
      end
   end

   assign busy          = (state == SHIFT);
   assign done          = (state == DONE);
   assign stall         = start | busy;
   assign Val2          = result;
   assign shifter_carry = carry;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Scoreboard bench for reg_shift_sequencer: a closed-form ARM shifter model predicts
// Val2, carry-out and SHIFT length; a monitor checks them whenever done pulses.
module tb_reg_shift_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  shift_type;
   logic [31:0] Val_Rm;
   logic [7:0]  Val_Rs;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] Val2;
   logic        shifter_carry;

   typedef struct {
      logic [31:0] val;
      logic        c;
      int          n;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;
   int   busyCnt;

   reg_shift_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .shift_type    (shift_type),
      .Val_Rm        (Val_Rm),
      .Val_Rs        (Val_Rs),
      .carry_in      (carry_in),
      .busy          (busy),
      .done          (done),
      .stall         (stall),
      .Val2          (Val2),
      .shifter_carry (shifter_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Architectural ARM barrel-shifter result, written directly from the shift definitions.
   function automatic logic [32:0] armShift(input logic [1:0] t, input logic [31:0] rm,
                                            input logic [7:0] rs, input logic cin);
      logic [31:0] r;
      logic        c;
      int          a;
      int          k;
      a = int'(rs);
      r = rm;
      c = cin;
      if (a != 0) begin
         case (t)
            2'b00: begin
               if (a < 32)       begin r = rm << a; c = rm[32 - a]; end
               else if (a == 32) begin r = '0; c = rm[0]; end
               else              begin r = '0; c = 1'b0; end
            end
            2'b01: begin
               if (a < 32)       begin r = rm >> a; c = rm[a - 1]; end
               else if (a == 32) begin r = '0; c = rm[31]; end
               else              begin r = '0; c = 1'b0; end
            end
            2'b10: begin
               if (a < 32) begin r = $unsigned($signed(rm) >>> a); c = rm[a - 1]; end
               else        begin r = {32{rm[31]}}; c = rm[31]; end
            end
            default: begin
               k = a % 32;
               if (k == 0) begin r = rm; c = rm[31]; end
               else        begin r = (rm >> k) | (rm << (32 - k)); c = rm[k - 1]; end
            end
         endcase
      end
      return {c, r};
   endfunction

   function automatic int shiftCycles(input logic [1:0] t, input logic [7:0] rs);
      int a;
      a = int'(rs);
      if (a == 0)       return 0;
      if (t == 2'b11)   return ((a % 32) == 0) ? 32 : (a % 32);
      if (t == 2'b10)   return (a > 32) ? 32 : a;
      return (a > 33) ? 33 : a;
   endfunction

   // Drives one request at a negedge, queues its prediction, returns at the negedge after the accept edge.
   task automatic applyStimulus(input logic [1:0] t, input logic [31:0] rm, input logic [7:0] rs, input logic cin);
      exp_t e;
      logic [32:0] m;
      m     = armShift(t, rm, rs, cin);
      e.val = m[31:0];
      e.c   = m[32];
      e.n   = shiftCycles(t, rs);
      sb.push_back(e);
      shift_type = t;
      Val_Rm     = rm;
      Val_Rs     = rs;
      carry_in   = cin;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitForDone();
      int cyc;
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1)
         checkOutput("done_timeout", {31'd0, done}, 32'd1);
   endtask

   // Monitor: counts SHIFT cycles, and on every done compares against the head of the queue.
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busyCnt++;
      end else if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", {31'd0, done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("val2", Val2, e.val);
            checkOutput("carry", {31'd0, shifter_carry}, {31'd0, e.c});
            checkOutput("busy_cycles", busyCnt, e.n);
         end
         busyCnt = 0;
      end else begin
         busyCnt = 0;
      end
   end

   logic [7:0] rsTable[12];

   initial begin
      vectors     = 0;
      miscompares = 0;
      busyCnt     = 0;
      rst         = 1'b1;
      start       = 1'b0;
      shift_type  = 2'b00;
      Val_Rm      = '0;
      Val_Rs      = '0;
      carry_in    = 1'b0;
      rsTable     = '{8'd0, 8'd1, 8'd4, 8'd31, 8'd32, 8'd33, 8'd40, 8'd64, 8'd200, 8'd255, 8'h24, 8'h20};

      repeat (3) @(negedge clk);
      checkOutput("rst_val2", Val2, 32'd0);
      checkOutput("rst_carry", {31'd0, shifter_carry}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_stall_lo", {31'd0, stall}, 32'd0);

      // start during reset: stall follows it, but reset wins the edge
      Val_Rm = 32'h1234_5678;
      Val_Rs = 8'd5;
      start  = 1'b1;
      #1 checkOutput("rst_stall_hi", {31'd0, stall}, 32'd1);
      @(negedge clk);
      checkOutput("rst_prio_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_prio_done", {31'd0, done}, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      applyStimulus(2'b00, 32'h0000_000F, 8'd4, 1'b0);
      checkOutput("shift_stall", {31'd0, stall}, 32'd1);
      waitForDone();
      checkOutput("done_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);

      applyStimulus(2'b01, 32'h8000_0001, 8'd32, 1'b0);
      waitForDone();
      @(negedge clk);
      applyStimulus(2'b00, 32'h8000_0001, 8'd40, 1'b1);
      waitForDone();
      @(negedge clk);
      applyStimulus(2'b10, 32'h8000_0000, 8'd200, 1'b0);
      waitForDone();
      @(negedge clk);
      applyStimulus(2'b11, 32'h8000_0000, 8'h20, 1'b0);
      waitForDone();
      @(negedge clk);

      applyStimulus(2'b11, 32'hCAFE_0001, 8'd0, 1'b1);
      checkOutput("rs0_done_t1", {31'd0, done}, 32'd1);
      checkOutput("rs0_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // start mid-SHIFT with other operands must not disturb the running ROR
      applyStimulus(2'b11, 32'h0000_001F, 8'h24, 1'b0);
      shift_type = 2'b00;
      Val_Rm     = 32'hFFFF_FFFF;
      Val_Rs     = 8'd1;
      carry_in   = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      checkOutput("ignored_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      waitForDone();

      // back-to-back: second request is raised while done is high
      applyStimulus(2'b00, 32'h0000_0001, 8'd3, 1'b0);
      waitForDone();
      applyStimulus(2'b01, 32'h8000_0001, 8'd7, 1'b0);
      checkOutput("b2b_no_gap", {31'd0, busy}, 32'd1);
      waitForDone();
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), $urandom, rsTable[i], 1'($urandom_range(0, 1)));
         waitForDone();
         @(negedge clk);
      end

      // reset during SHIFT cycle 3 of a 10-cycle op drops it entirely
      applyStimulus(2'b00, 32'h0F0F_0F0F, 8'd10, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_rst_val2", Val2, 32'd0);
      checkOutput("mid_rst_carry", {31'd0, shifter_carry}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
      repeat (15) @(negedge clk);

      checkOutput("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_shift_sequencer.md
# reg_shift_sequencer

Multi-cycle sequencer for ARM register-specified shifts, where the shift amount comes from Rs[7:0] rather than the immediate field. It sits in the execute stage beside the immediate Val2 generator. When decode flags a register shift, it takes over Val2 production and holds the pipeline via `stall` until the shifted operand and shifter carry-out are ready. It is an iterative 1-bit/cycle shifter under a three-state FSM, and implements full ARM semantics for amounts of 0, 32 and above 32.

## Interface
Parameters:
- none (datapath fixed at 32 bits, shift amount at 8 bits)

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge
- `rst`  in  1  — synchronous, active-high reset
- `start`  in  1  — request; sampled on rising edge, accepted only in IDLE or DONE
- `shift_type`  in  2  — 00 LSL, 01 LSR, 10 ASR, 11 ROR
- `Val_Rm`  in  32  — operand to shift, latched on accept
- `Val_Rs`  in  8  — shift amount (Rs[7:0]), latched on accept
- `carry_in`  in  1  — current C flag, latched on accept
- `busy`  out  1  — high while in SHIFT
- `done`  out  1  — one-cycle pulse in DONE; `Val2`/`shifter_carry` valid
- `stall`  out  1  — combinational `start | busy`; freezes upstream pipeline
- `Val2`  out  32  — shifted operand
- `shifter_carry`  out  1  — shifter carry-out

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept (IDLE or DONE with `start`=1):
  - latch `Val_Rm` into the result register, `shift_type` into a type register, `carry_in` into the carry register
  - load the 6-bit counter with the effective count n
  - go to SHIFT if n>0, else DONE
- Effective count n:
  - LSL/LSR: min(Rs,33)
  - ASR: min(Rs,32)
  - ROR: 0 if Rs==0; 32 if Rs[4:0]==0 and Rs!=0; else Rs[4:0]
- SHIFT, per cycle (one bit):
  - LSL: carry←r[31], r←{r[30:0],0}
  - LSR: carry←r[0], r←{0,r[31:1]}
  - ASR: carry←r[0], r←{r[31],r[31:1]}
  - ROR: carry←r[0], r←{r[0],r[31:1]}
  - counter decrements; on the edge where the counter goes 1→0, next state is DONE
- Resulting semantics, which must hold:
  - LSL/LSR by 32: result 0, carry = Rm[0] (LSL) or Rm[31] (LSR)
  - LSL/LSR by more than 32: result 0, carry 0
  - ASR by 32 or more: result and carry are all Rm[31]
  - ROR by a nonzero multiple of 32: result Rm, carry Rm[31]
  - Rs==0 (any type): result Rm, carry = `carry_in`
- DONE: `done`=1 for one cycle. Next state is SHIFT/DONE if a new start is accepted, else IDLE.
- `start` in SHIFT is ignored: no latch, no restart. `stall` remains high regardless.
- `Val2`/`shifter_carry` are the result/carry registers. They hold their value from DONE until the next accept.
- Reset in any state:
  - next state IDLE
  - `Val2`=0, `shifter_carry`=0, counter=0
  - `busy`=0, `done`=0
  - any in-flight shift is discarded
- `rst` has priority over `start` in the same cycle.

## Timing
- Reset values: `Val2`=0, `shifter_carry`=0, `busy`=0, `done`=0. `stall` follows `start` combinationally.
- Latency: with accept at edge T, SHIFT occupies cycles T+1..T+n and `done` is high in cycle T+n+1.
  - n=0: `done` in T+1
  - worst case n=33: `done` in T+34
- `busy` is high exactly n cycles. `stall` is high from the accept cycle through the last SHIFT cycle and low in DONE, unless `start` is reasserted.
- Back-to-back: `start` held during DONE is accepted at that edge, giving zero idle cycles between operations.

## Test plan
- LSL, Rm=0x0000000F, Rs=4, C=0 → Val2=0x000000F0, carry=0; `busy` high 4 cycles; `done` 5 cycles after accept.
- LSR, Rm=0x80000001, Rs=32 → Val2=0, carry=1. LSL Rs=40 of the same Rm → Val2=0, carry=0; 33 busy cycles.
- ASR, Rm=0x80000000, Rs=200 → Val2=0xFFFFFFFF, carry=1; 32 busy cycles.
- ROR, Rm=0x0000001F, Rs=0x24 → Val2=0xF0000001, carry=1.
  - ROR Rm=0x80000000, Rs=0x20 → Val2=0x80000000, carry=1.
  - Rs=0 with C=1 → Val2=Rm, carry=1, `done` at T+1, `busy` never high.
- `start` pulsed mid-SHIFT with different operands → ignored, original result unchanged. `start` held through DONE → second op accepted with no gap.
- `rst` asserted in SHIFT cycle 3 of a 10-cycle op → next cycle IDLE, `Val2`=0, `busy`=`done`=0, no `done` pulse afterward.
